// File: rtl/image_stream_ctrl.sv
// Raster read sequencer: walks one frame of the pixel store with VSYNC/HSYNC framing.
// Build option ROW_FLIP_EN selects bottom-up (BMP order) read addressing.
module image_stream_ctrl #(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int ADDR_W         = 19
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pix_valid,
  output logic [9:0]        pix_row,
  output logic [10:0]       pix_col,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic              busy,
  output logic              frame_done
);

  localparam int DLY_MAX = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
  localparam int CNT_W   = $clog2(DLY_MAX + 1);

`ifdef ROW_FLIP_EN
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'((HEIGHT - 1) * WIDTH);
  // Row wrap jumps back from the end of this row to the start of the row above it.
  localparam logic [ADDR_W-1:0] ADDR_WRAP  = ADDR_W'(2 * WIDTH - 1);
`else
  localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VSYNC = 3'd1,
    S_HSYNC = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [9:0]         r_row;
  logic [10:0]        r_col;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_pix_valid;
  logic [9:0]         r_pix_row;
  logic [10:0]        r_pix_col;

  logic w_vs_last;
  logic w_hs_last;
  logic w_col_last;
  logic w_row_last;
  logic w_consume;

  assign w_vs_last  = (r_cnt == CNT_W'(START_UP_DELAY - 1));
  assign w_hs_last  = (r_cnt == CNT_W'(HSYNC_DELAY - 1));
  assign w_col_last = (r_col == 11'(WIDTH - 1));
  assign w_row_last = (r_row == 10'(HEIGHT - 1));
  assign w_consume  = (r_state == S_DATA) && out_ready;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    rd_en       = 1'b0;
    VSYNC       = 1'b0;
    HSYNC       = 1'b0;
    busy        = 1'b1;
    frame_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_VSYNC;
      end
      S_VSYNC: begin
        VSYNC = 1'b1;
        if (w_vs_last) w_state_nxt = S_HSYNC;
      end
      S_HSYNC: begin
        if (w_hs_last) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        HSYNC = 1'b1;
        rd_en = out_ready;
        if (w_consume && w_col_last) w_state_nxt = w_row_last ? S_DONE : S_HSYNC;
      end
      S_DONE: begin
        frame_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
    // Abort overrides every transition, including a start seen in IDLE.
    if (abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt  <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (abort || (r_state == S_DONE)) begin
      r_cnt  <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt  <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= ADDR_FIRST;
          end
        end
        S_VSYNC: r_cnt <= w_vs_last ? '0 : r_cnt + 1'b1;
        S_HSYNC: r_cnt <= w_hs_last ? '0 : r_cnt + 1'b1;
        S_DATA: begin
          // Address advances incrementally so no row*WIDTH product is ever formed.
          if (w_consume) begin
            if (w_col_last) begin
              if (!w_row_last) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
`ifdef ROW_FLIP_EN
                r_addr <= r_addr - ADDR_WRAP;
`else
                r_addr <= r_addr + 1'b1;
`endif
              end
            end else begin
              r_col  <= r_col + 1'b1;
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read-data stage: memory returns the pixel one cycle after rd_en.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pix_valid <= 1'b0;
      r_pix_row   <= '0;
      r_pix_col   <= '0;
    end else begin
      r_pix_valid <= rd_en;
      r_pix_row   <= r_row;
      r_pix_col   <= r_col;
    end
  end

  assign rd_addr   = r_addr;
  assign pix_valid = r_pix_valid;
  assign pix_row   = r_pix_row;
  assign pix_col   = r_pix_col;

endmodule

// File: tb/tb_image_stream_ctrl.sv
// Self-checking bench for image_stream_ctrl on a small 4x3 frame with random back-pressure.
module tb_image_stream_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int SD = 5;
  localparam int HD = 3;
  localparam int AW = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          start;
  logic          abort;
  logic          out_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          pix_valid;
  logic [9:0]    pix_row;
  logic [10:0]   pix_col;
  logic          VSYNC;
  logic          HSYNC;
  logic          busy;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  image_stream_ctrl #(
    .WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SD), .HSYNC_DELAY(HD), .ADDR_W(AW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort), .out_ready(out_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .pix_valid(pix_valid), .pix_row(pix_row),
    .pix_col(pix_col), .VSYNC(VSYNC), .HSYNC(HSYNC), .busy(busy), .frame_done(frame_done)
  );

  always #5 HCLK = ~HCLK;

  function automatic int addr_of(input int r, input int c);
`ifdef ROW_FLIP_EN
    return (H - 1 - r) * W + c;
`else
    return r * W + c;
`endif
  endfunction

  task automatic test_reset();
    @(negedge HCLK); #1;
    n_checks++;
    if ({rd_en, pix_valid, VSYNC, HSYNC, busy, frame_done} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {rd_en, pix_valid, VSYNC, HSYNC, busy, frame_done});
    end
    n_checks++;
    if (rd_addr !== '0 || pix_row !== '0 || pix_col !== '0) begin
      n_fail++; $display("FAIL reset_data: addr=%0d row=%0d col=%0d want 0", rd_addr, pix_row, pix_col);
    end
    @(negedge HCLK); HRESETn = 1'b1;
    @(negedge HCLK); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  // One whole frame, checked against frame-level expectations derived from the geometry.
  task automatic test_frame(input int pct, input bit stall6);
    int  vs_rise = -1, vs_len = 0, stalls = 0, idx = 0, blank = 0, stall_left = 3;
    int  prev_r = 0, prev_c = 0, exp_len;
    bit  prev_rd = 0, prev_hs = 0, done = 0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge HCLK);
      start = (cyc == 0);
      if (stall6) out_ready = !(HSYNC && rd_addr == AW'(6) && stall_left > 0);
      else out_ready = ($urandom_range(0, 99) < pct);
      if (stall6 && HSYNC && !out_ready) stall_left--;
      #1;
      n_checks++;
      if (pix_valid !== prev_rd) begin
        n_fail++; $display("FAIL pix_valid cyc%0d: got %b want %b", cyc, pix_valid, prev_rd);
      end
      if (prev_rd) begin
        n_checks++;
        if (pix_row !== 10'(prev_r) || pix_col !== 11'(prev_c)) begin
          n_fail++; $display("FAIL pix_rc cyc%0d: got %0d,%0d want %0d,%0d", cyc, pix_row, pix_col, prev_r, prev_c);
        end
      end
      n_checks++;
      if (rd_en !== (HSYNC && out_ready)) begin
        n_fail++; $display("FAIL rd_en cyc%0d: got %b want %b", cyc, rd_en, HSYNC && out_ready);
      end
      if (HSYNC && !out_ready) begin
        stalls++;
        if (stall6) begin
          n_checks++;
          if (rd_addr !== AW'(6)) begin n_fail++; $display("FAIL stall_hold: addr=%0d want 6", rd_addr); end
        end
      end
      if (VSYNC) begin
        if (vs_rise < 0) vs_rise = cyc;
        vs_len++;
      end
      if (busy && !VSYNC && !HSYNC && !frame_done) blank++;
      if (HSYNC && !prev_hs) begin
        n_checks++;
        if (blank != HD) begin n_fail++; $display("FAIL blanking: got %0d cycles want %0d", blank, HD); end
        blank = 0;
      end
      if (rd_en) begin
        n_checks++;
        if (idx >= W * H) begin
          n_fail++; $display("FAIL extra_read: read %0d want %0d", idx + 1, W * H);
        end else if (rd_addr !== AW'(addr_of(idx / W, idx % W))) begin
          n_fail++; $display("FAIL rd_addr #%0d: got %0d want %0d", idx, rd_addr, addr_of(idx / W, idx % W));
        end
        prev_r = idx / W;
        prev_c = idx % W;
        idx++;
      end
      prev_rd = rd_en;
      prev_hs = HSYNC;
      if (frame_done) begin
        done = 1;
        exp_len = SD + H * (HD + W) + stalls;
        n_checks++;
        if (cyc - vs_rise != exp_len) begin
          n_fail++; $display("FAIL frame_len: got %0d want %0d", cyc - vs_rise, exp_len);
        end
        n_checks++;
        if (idx != W * H || vs_len != SD) begin
          n_fail++; $display("FAIL frame_count: reads=%0d vsync=%0d want %0d,%0d", idx, vs_len, W * H, SD);
        end
        if (stall6) begin
          n_checks++;
          if (stalls != 3) begin n_fail++; $display("FAIL stall_count: got %0d want 3", stalls); end
        end
      end
    end
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL frame_timeout: frame_done=0 want 1"); end
    @(negedge HCLK); out_ready = 1'b0; #1;
    n_checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL post_frame: busy=%b done=%b want 0,0", busy, frame_done);
    end
  endtask

  task automatic test_abort();
    bit hit = 0;
    @(negedge HCLK); start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge HCLK); start = 1'b0;
      #1;
      if (HSYNC && rd_addr == AW'(addr_of(2, 1))) begin abort = 1'b1; hit = 1; end
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL abort_reach: hit=0 want 1"); end
    @(negedge HCLK); abort = 1'b0; #1;
    n_checks++;
    if ({busy, VSYNC, HSYNC, rd_en, frame_done} !== 5'b0 || rd_addr !== '0) begin
      n_fail++; $display("FAIL abort_idle: flags=%b addr=%0d want 00000,0", {busy, VSYNC, HSYNC, rd_en, frame_done}, rd_addr);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK); #1;
      n_checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL abort_quiet: done=%b busy=%b want 0,0", frame_done, busy);
      end
    end
  endtask

  task automatic test_start_ignored();
    int n_done = 0;
    bit pulsed = 0;
    @(negedge HCLK); start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge HCLK); start = 1'b0;
      if (!pulsed && HSYNC && rd_addr == AW'(addr_of(1, 0))) begin start = 1'b1; pulsed = 1; end
      #1;
      if (frame_done) n_done++;
    end
    n_checks++;
    if (!pulsed || n_done != 1) begin
      n_fail++; $display("FAIL start_busy: frame_done count=%0d pulsed=%b want 1,1", n_done, pulsed);
    end
    @(negedge HCLK); start = 1'b1; abort = 1'b1;
    @(negedge HCLK); start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge HCLK); #1;
      n_checks++;
      if (busy !== 1'b0 || VSYNC !== 1'b0) begin
        n_fail++; $display("FAIL start_abort_idle: busy=%b vsync=%b want 0,0", busy, VSYNC);
      end
    end
  endtask

  task automatic test_async_reset();
    bit seen_vs = 0, hit = 0;
    @(negedge HCLK); start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge HCLK); start = 1'b0; #1;
      if (VSYNC) seen_vs = 1;
      else if (seen_vs && busy && !HSYNC) hit = 1;
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL areset_reach: hit=0 want 1"); end
    @(posedge HCLK); #3; HRESETn = 1'b0; #1;
    n_checks++;
    if ({rd_en, pix_valid, VSYNC, HSYNC, busy, frame_done} !== 6'b0 || rd_addr !== '0 ||
        pix_row !== '0 || pix_col !== '0) begin
      n_fail++; $display("FAIL areset_outputs: flags=%b addr=%0d want 000000,0",
                         {rd_en, pix_valid, VSYNC, HSYNC, busy, frame_done}, rd_addr);
    end
    @(negedge HCLK); HRESETn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK); #1;
      n_checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0 || VSYNC !== 1'b0 || frame_done !== 1'b0) begin
        n_fail++; $display("FAIL areset_quiet: busy=%b rd_en=%b want 0,0", busy, rd_en);
      end
    end
  endtask

  initial begin
    HRESETn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    test_reset();
    test_frame(100, 1'b0);
    test_frame(100, 1'b1);
    for (int k = 0; k < 4; k++) test_frame(30 + 15 * k, 1'b0);
    test_abort();
    test_frame(100, 1'b0);
    test_start_ignored();
    test_async_reset();
    test_frame(70, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
